reg_dump_reader: RTL and testbench

Sequential reader for the CPU's 32×32 register file. On a start pulse it walks an inclusive register range through one read port and streams each word, with its index, to a debug consumer (seven-segment display or UART) over a valid/ready handshake. It sits beside the pipeline on the Nexys 4 DDR board and owns a dedicated read port of the register file.

---
 rtl/regdump_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 92 +++++++++
 tb/tb_reg_dump_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
package regdump_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } regdump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks an inclusive, wrapping register range through one read port
// and streams (index, word) pairs over a valid/ready handshake.
module reg_dump_reader #(
  parameter int NUM_REGS = regdump_pkg::NUM_REGS,
  parameter int ADDR_W   = regdump_pkg::ADDR_W,
  parameter int DATA_W   = regdump_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import regdump_pkg::*;

  regdump_state_t    state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_reg;
  logic [ADDR_W-1:0] nxt;

  assign nxt = ADDR_W'((32'(cur) + 32'd1) % NUM_REGS);

  // cur only moves on handshake, so the address stays put under stall
  assign rd_addr = (state == IDLE) ? '0 : cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      end_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur     <= first_reg;
            end_reg <= last_reg;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= cur;
          out_last  <= (cur == end_reg);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur   <= nxt;
              state <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Random and directed dumps checked against a word-list model
// built from range arithmetic over a behavioural register file.
module tb_reg_dump_reader;
  import regdump_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf [NUM_REGS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_word(input int idx);
    return (idx == 0) ? '0 : rf[idx];
  endfunction

  // mode 0: ready high, 1: random ready, 2: stall 2nd word 4 cycles
  task automatic dump(input int f, input int l, input int mode,
                      input int wr_after, input int wr_idx,
                      input logic [DATA_W-1:0] wr_val);
    int n;
    int got;
    int k;
    int stall;
    int idx;
    n = ((l - f + NUM_REGS) % NUM_REGS) + 1;
    got = 0;
    k = 0;
    stall = 0;
    @(negedge clk);
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_reg = ADDR_W'($urandom);
    last_reg  = ADDR_W'($urandom);
    while (!done && k < 600) begin
      chk("busy", busy, 1);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = !(out_valid && got == 1 && stall < 4);
          if (!out_ready) stall++;
        end
      endcase
      if (out_valid) begin
        idx = (f + got) % NUM_REGS;
        chk("index", out_index, idx);
        chk("data", out_data, ref_word(idx));
        chk("last", out_last, (got == n - 1));
        chk("rd_addr", rd_addr, idx);
        if (out_ready) begin
          got++;
          if (got == wr_after) rf[wr_idx] = wr_val;
        end
      end
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
    chk("word_count", got, n);
    if (mode == 0) chk("done_latency", k, 2 * n);
    if (mode == 2) chk("stall_cycles", stall, (n > 1) ? 4 : 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    chk("rd_addr_idle", rd_addr, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    first_reg = '0;
    last_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(32'h100 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    dump(3, 5, 0, -1, 0, '0);
    dump(30, 1, 0, -1, 0, '0);
    dump(8, 12, 2, -1, 0, '0);

    // second start mid-dump is ignored, abort in SEND drops valid
    @(negedge clk);
    out_ready = 1'b1;
    first_reg = 5'd10;
    last_reg = 5'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_rd_addr0", rd_addr, 10);
    @(negedge clk);
    chk("ab_valid0", out_valid, 1);
    chk("ab_index0", out_index, 10);
    first_reg = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_rd_addr1", rd_addr, 11);
    @(negedge clk);
    chk("ab_index1", out_index, 11);
    chk("ab_data1", out_data, 32'h10B);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid_drop", out_valid, 0);
    chk("ab_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_no_done", done, 0);
    end

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("ab_idle_busy", busy, 0);
    @(negedge clk);
    chk("ab_idle_valid", out_valid, 0);

    // reset during READ
    first_reg = 5'd0;
    last_reg = 5'd31;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_in_read", rd_addr, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("midrst");
    dump(7, 7, 0, -1, 0, '0);

    dump(0, 31, 0, 5, 20, 32'hDEAD);
    chk("reg20_model", rf[20], 32'hDEAD);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
      dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 2)), -1, 0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
